// File: rtl/awgn_channel_add_if.sv
// awgn_channel_add_if: noise, symbol and output streams of the AWGN channel adder
//  noise_v/noise_x0/noise_x1 : Box-Muller pair input, no backpressure
//  sigma                     : unsigned noise scale UQ(W-SIGMA_FRAC).SIGMA_FRAC
//  sig_valid/sig_ready/sig_data : signed input symbol stream
//  out_valid/out_ready/out_data/out_sat : noisy saturated symbol stream
//  ovf, fifo_level           : sticky pair-drop flag and stored pair count
interface awgn_channel_add_if #(parameter int W = 16, parameter int DEPTH = 4);
  logic noise_v;
  logic [W-1:0] noise_x0;
  logic [W-1:0] noise_x1;
  logic [W-1:0] sigma;
  logic sig_valid;
  logic sig_ready;
  logic [W-1:0] sig_data;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic out_sat;
  logic ovf;
  logic [$clog2(DEPTH):0] fifo_level;
  modport master (
    output noise_v, noise_x0, noise_x1, sigma, sig_valid, sig_data, out_ready,
    input sig_ready, out_valid, out_data, out_sat, ovf, fifo_level
  );
  modport slave (
    input noise_v, noise_x0, noise_x1, sigma, sig_valid, sig_data, out_ready,
    output sig_ready, out_valid, out_data, out_sat, ovf, fifo_level
  );
endinterface

// File: rtl/awgn_channel_add.sv
// awgn_channel_add: buffers BM noise pairs, scales by sigma, adds to symbols, saturates
//  clk   : rising-edge clock
//  reset : asynchronous active-high, clears all state
//  bus   : awgn_channel_add_if slave (noise pairs in, symbols in, noisy symbols out)
module awgn_channel_add #(
  parameter int W = 16,
  parameter int SIGMA_FRAC = 15,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  awgn_channel_add_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = 2 * W + 1;
  logic [W-1:0] mem0 [DEPTH];
  logic [W-1:0] mem1 [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] level;
  logic h;
  logic signed [PW-1:0] p1;
  logic signed [W-1:0] d1;
  logic v1;
  logic adv, accept, pop, full, push, hi, lo;
  logic signed [W-1:0] noise_sel;
  logic signed [PW:0] s;
  always_comb begin
    adv = !bus.out_valid || bus.out_ready;
    bus.sig_ready = (level != '0) && adv;
    bus.fifo_level = level;
    accept = bus.sig_valid && bus.sig_ready;
    pop = accept && h;
    full = level == (AW+1)'(DEPTH);
    // a pop in the same cycle frees the slot, so a full FIFO still takes the pair
    push = bus.noise_v && (!full || pop);
    noise_sel = h ? mem1[rptr] : mem0[rptr];
    s = (PW+1)'(d1) + (PW+1)'(p1 >>> SIGMA_FRAC);
    // fits in W bits only when bits above W-2 all equal the sign
    hi = !s[PW] && |s[PW-1:W-1];
    lo = s[PW] && !(&s[PW-1:W-1]);
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem0[wptr] <= bus.noise_x0;
      mem1[wptr] <= bus.noise_x1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      h <= 1'b0;
      bus.ovf <= 1'b0;
      p1 <= '0;
      d1 <= '0;
      v1 <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_sat <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (bus.noise_v && full && !pop) bus.ovf <= 1'b1;
      if (accept) h <= !h;
      if (adv) begin
        v1 <= accept;
        if (accept) begin
          p1 <= PW'(noise_sel) * PW'($signed({1'b0, bus.sigma}));
          d1 <= bus.sig_data;
        end
        bus.out_valid <= v1;
        if (v1) begin
          bus.out_data <= hi ? {1'b0, {(W-1){1'b1}}} : lo ? {1'b1, {(W-1){1'b0}}} : s[W-1:0];
          bus.out_sat <= hi || lo;
        end
      end
    end
  end
endmodule

// File: tb/tb_awgn_channel_add.sv
// tb_awgn_channel_add: directed and randomized self-checking bench for awgn_channel_add
module tb_awgn_channel_add;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  logic [15:0] ns_q[$];
  logic hold_pend = 1'b0;
  logic [16:0] hold_val;
  logic [15:0] t5e [8];
  always #5 clk = ~clk;
  awgn_channel_add_if #(.W(16), .DEPTH(4)) bus();
  awgn_channel_add #(.W(16), .SIGMA_FRAC(15), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  function automatic logic [16:0] model(input logic [15:0] sig, input logic [15:0] noise, input logic [15:0] sg);
    longint p, v;
    p = longint'($signed(noise)) * longint'(sg);
    v = longint'($signed(sig)) + (p >>> 15);
    if (v > 32767) return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction
  task automatic push(input logic [15:0] a, input logic [15:0] b);
    bus.noise_x0 = a;
    bus.noise_x1 = b;
    bus.noise_v = 1'b1;
    tick();
    bus.noise_v = 1'b0;
  endtask
  task automatic send(input logic [15:0] d, input logic [15:0] sg, input logic [16:0] e);
    bus.sig_data = d;
    bus.sigma = sg;
    bus.sig_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.sig_ready; i++) tick();
    chk("accept_wait", 32'(bus.sig_ready), 1);
    exp_q.push_back(e);
    tick();
    bus.sig_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (reset) hold_pend = 1'b0;
    else begin
      if (hold_pend && bus.out_valid) chk("hold", {bus.out_sat, bus.out_data}, hold_val);
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL extra_out: observed %h expected nothing", {bus.out_sat, bus.out_data});
        end
        if (exp_q.size() != 0) chk("out", {bus.out_sat, bus.out_data}, exp_q.pop_front());
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val = {bus.out_sat, bus.out_data};
    end
  end
  initial begin
    int acc, cyc;
    bus.noise_v = 1'b0;
    bus.noise_x0 = '0;
    bus.noise_x1 = '0;
    bus.sigma = '0;
    bus.sig_valid = 1'b0;
    bus.sig_data = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_level", 32'(bus.fifo_level), 0);
    chk("rst_sig_ready", 32'(bus.sig_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    // T1: async reset mid-stream with level 3 and a stalled output
    push(16'h0100, 16'hFF00);
    push(16'h0200, 16'h0010);
    push(16'h0300, 16'h0020);
    chk("t1_level3", 32'(bus.fifo_level), 3);
    bus.out_ready = 1'b0;
    send(16'h0010, 16'h8000, {1'b0, 16'h0110});
    tick();
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_out_data", 32'(bus.out_data), 32'h0110);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t1_async_valid", 32'(bus.out_valid), 0);
    chk("t1_async_data", 32'(bus.out_data), 0);
    chk("t1_async_sat", 32'(bus.out_sat), 0);
    chk("t1_async_level", 32'(bus.fifo_level), 0);
    chk("t1_async_ovf", 32'(bus.ovf), 0);
    chk("t1_async_ready", 32'(bus.sig_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    bus.sig_valid = 1'b1;
    tick();
    chk("t1_ready_empty_a", 32'(bus.sig_ready), 0);
    tick();
    chk("t1_ready_empty_b", 32'(bus.sig_ready), 0);
    bus.sig_valid = 1'b0;
    chk("t1_no_noiseless", 32'(bus.out_valid), 0);
    // T2: serialisation order x0,x1 of each pair with unity sigma
    push(16'h0100, 16'hFF00);
    push(16'h0200, 16'h0010);
    chk("t2_level2", 32'(bus.fifo_level), 2);
    bus.sigma = 16'h8000;
    bus.sig_data = 16'h0000;
    bus.sig_valid = 1'b1;
    exp_q.push_back({1'b0, 16'h0100});
    exp_q.push_back({1'b0, 16'hFF00});
    exp_q.push_back({1'b0, 16'h0200});
    exp_q.push_back({1'b0, 16'h0010});
    for (int i = 0; i < 4; i++) begin
      chk("t2_ready", 32'(bus.sig_ready), 1);
      tick();
    end
    bus.sig_valid = 1'b0;
    repeat (4) tick();
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_level0", 32'(bus.fifo_level), 0);
    // T3: half-scale sigma, latency, floor of negative product
    push(16'h0800, 16'hFFFF);
    send(16'h1000, 16'h4000, {1'b0, 16'h1400});
    chk("t3_lat_a", 32'(bus.out_valid), 0);
    tick();
    chk("t3_lat_b", 32'(bus.out_valid), 1);
    chk("t3_data", 32'(bus.out_data), 32'h1400);
    send(16'h0000, 16'h4000, {1'b0, 16'hFFFF});
    repeat (3) tick();
    chk("t3_drained", exp_q.size(), 0);
    // T4: saturation both ways and exact-fit boundaries
    push(16'h0200, 16'hFE00);
    push(16'h0200, 16'h0000);
    send(16'h7F00, 16'h8000, {1'b1, 16'h7FFF});
    send(16'h8100, 16'h8000, {1'b1, 16'h8000});
    send(16'h7DFF, 16'h8000, {1'b0, 16'h7FFF});
    send(16'h8000, 16'h8000, {1'b0, 16'h8000});
    repeat (3) tick();
    chk("t4_drained", exp_q.size(), 0);
    // T5: overflow drop and push+pop at full
    chk("t5_level0", 32'(bus.fifo_level), 0);
    push(16'h0001, 16'h0002);
    push(16'h0003, 16'h0004);
    push(16'h0005, 16'h0006);
    push(16'h0007, 16'h0008);
    chk("t5_level4", 32'(bus.fifo_level), 4);
    chk("t5_ovf0", 32'(bus.ovf), 0);
    push(16'h0009, 16'h000A);
    chk("t5_level_drop", 32'(bus.fifo_level), 4);
    chk("t5_ovf1", 32'(bus.ovf), 1);
    send(16'h0000, 16'h8000, {1'b0, 16'h0001});
    chk("t5_level_h1", 32'(bus.fifo_level), 4);
    bus.noise_x0 = 16'h000B;
    bus.noise_x1 = 16'h000C;
    bus.noise_v = 1'b1;
    bus.sig_valid = 1'b1;
    #1;
    chk("t5_pp_ready", 32'(bus.sig_ready), 1);
    exp_q.push_back({1'b0, 16'h0002});
    tick();
    bus.noise_v = 1'b0;
    bus.sig_valid = 1'b0;
    chk("t5_pp_level", 32'(bus.fifo_level), 4);
    chk("t5_pp_ovf", 32'(bus.ovf), 1);
    t5e = '{16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h000B, 16'h000C};
    for (int i = 0; i < 8; i++) send(16'h0000, 16'h8000, {1'b0, t5e[i]});
    repeat (3) tick();
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_level_end", 32'(bus.fifo_level), 0);
    reset = 1'b1;
    exp_q.delete();
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("ovf_cleared", 32'(bus.ovf), 0);
    // T6: random backpressure and symbol gaps against the arithmetic model
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      bus.out_ready = $urandom_range(0, 99) < 30;
      bus.sig_valid = 1'($urandom_range(0, 1));
      bus.sig_data = 16'($urandom);
      bus.sigma = 16'($urandom);
      bus.noise_x0 = 16'($urandom);
      bus.noise_x1 = 16'($urandom);
      bus.noise_v = (bus.fifo_level <= 2) && 1'($urandom_range(0, 1));
      #1;
      chk("t6_ready", 32'(bus.sig_ready), 32'(ns_q.size() != 0 && (!bus.out_valid || bus.out_ready)));
      if (bus.sig_valid && bus.sig_ready) begin
        exp_q.push_back(model(bus.sig_data, ns_q.pop_front(), bus.sigma));
        acc++;
      end
      if (bus.noise_v) begin
        ns_q.push_back(bus.noise_x0);
        ns_q.push_back(bus.noise_x1);
      end
      tick();
      cyc++;
    end
    chk("t6_count", acc, 1000);
    bus.sig_valid = 1'b0;
    bus.noise_v = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) tick();
    chk("t6_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
